alu_sequencer: RTL and testbench

Program-driven controller for the register-file/ALU datapath. It fetches 16-bit instructions from a synchronous instruction ROM and decodes each one into the datapath control bundle: regEnable, flagEn, RorI, opcode, Rsrc, Rdest and imm. It runs until it reaches a HALT word. It sits between the instruction memory and the existing register file/ALU, and replaces hard-coded test sequencers.

---
 rtl/alu_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
// -------------
// This controller fetches 16-bit instructions from a synchronous instruction
// ROM. It decodes each one into the control bundle for the register-file/ALU
// datapath, and runs until it reaches the HALT word (16'h0000).
// Each instruction takes three cycles: FETCH (address out), WAIT (ROM data
// arrives and is latched together with its decode), EXEC (controls valid).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse; starts at PC=0 (honoured in IDLE/HALT only)
//   instr_addr  ROM address (= PC)
//   instr_data  ROM read data, valid one cycle after instr_addr
//   regEnable   one-hot register write enable, indexed by Rdest
//   flagEn      PSR flag update enable
//   RorI        operand select: 0 = register Rsrc, 1 = imm
//   opcode      {instr[15:12], instr[7:4]}
//   Rsrc        instr[3:0]
//   Rdest       instr[11:8]
//   imm         extended immediate (0 for register forms)
//   busy        high in FETCH/WAIT/EXEC
//   halted      high in HALT
//   illegal     sticky undecodable-word flag, cleared by rst or an honoured start
module alu_sequencer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [15:0]       instr_data,
   output logic [15:0]       regEnable,
   output logic              flagEn,
   output logic              RorI,
   output logic [7:0]        opcode,
   output logic [3:0]        Rsrc,
   output logic [3:0]        Rdest,
   output logic [15:0]       imm,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   typedef struct packed {
      logic        legal;
      logic [15:0] reg_en;
      logic        flag_en;
      logic        rori;
      logic [15:0] imm;
   } dec_t;

   localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Decode one instruction word into its enables and immediate. The HALT
   // word is reported as legal so that it does not raise the illegal flag.
   function automatic dec_t decode_word(input logic [15:0] w);
      dec_t       d;
      logic       wr;
      logic [3:0] op;
      logic [3:0] ext;
      op  = w[15:12];
      ext = w[7:4];
      d   = '0;
      wr  = 1'b0;
      if (w == 16'h0000) begin
         d.legal = 1'b1;
      end else begin
         case (op)
            4'h0: begin
               case (ext)
                  4'h1, 4'h2, 4'h3, 4'hD: begin
                     d.legal = 1'b1;
                     wr      = 1'b1;
                  end
                  4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hE: begin
                     d.legal   = 1'b1;
                     wr        = 1'b1;
                     d.flag_en = 1'b1;
                  end
                  4'hB: begin
                     d.legal   = 1'b1;
                     d.flag_en = 1'b1;
                  end
                  default: d.legal = 1'b0;
               endcase
            end
            // logic immediates and MOVI: zero-extended, no flags
            4'h1, 4'h2, 4'h3, 4'hD: begin
               d.legal = 1'b1;
               wr      = 1'b1;
               d.rori  = 1'b1;
               d.imm   = {8'h00, w[7:0]};
            end
            // ADDUI: zero-extended but updates flags
            4'h6: begin
               d.legal   = 1'b1;
               wr        = 1'b1;
               d.flag_en = 1'b1;
               d.rori    = 1'b1;
               d.imm     = {8'h00, w[7:0]};
            end
            4'h5, 4'h7, 4'h9, 4'hA, 4'hE: begin
               d.legal   = 1'b1;
               wr        = 1'b1;
               d.flag_en = 1'b1;
               d.rori    = 1'b1;
               d.imm     = {{8{w[7]}}, w[7:0]};
            end
            // CMPI: flags only, no register write
            4'hB: begin
               d.legal   = 1'b1;
               d.flag_en = 1'b1;
               d.rori    = 1'b1;
               d.imm     = {{8{w[7]}}, w[7:0]};
            end
            4'h8: begin
               case (ext)
                  4'h8, 4'hF: begin
                     d.legal = 1'b1;
                     wr      = 1'b1;
                  end
                  // shift-by-immediate: 5-bit signed amount {IR[4], IR[3:0]}
                  4'h0, 4'h1, 4'h2, 4'h3: begin
                     d.legal = 1'b1;
                     wr      = 1'b1;
                     d.rori  = 1'b1;
                     d.imm   = {{11{w[4]}}, w[4:0]};
                  end
                  default: d.legal = 1'b0;
               endcase
            end
            default: d.legal = 1'b0;
         endcase
      end
      if (wr) begin
         d.reg_en = 16'h0001 << w[11:8];
      end else begin
         d.reg_en = 16'h0000;
      end
      return d;
   endfunction

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [15:0]       ir_r, ir_s;
   logic [15:0]       reg_en_r, reg_en_s;
   logic              flag_en_r, flag_en_s;
   logic              rori_r, rori_s;
   logic [7:0]        opcode_r, opcode_s;
   logic [3:0]        rsrc_r, rsrc_s;
   logic [3:0]        rdest_r, rdest_s;
   logic [15:0]       imm_r, imm_s;
   logic              busy_r, busy_s;
   logic              halted_r, halted_s;
   logic              illegal_r, illegal_s;
   dec_t              dec_s;

   assign dec_s = decode_word(instr_data);

   // Next-state and next-output logic. Control outputs are loaded on the
   // WAIT->EXEC edge so that they are registered and valid for the EXEC cycle
   // only. They return to zero on every other edge.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      ir_s      = ir_r;
      reg_en_s  = 16'h0000;
      flag_en_s = 1'b0;
      rori_s    = 1'b0;
      opcode_s  = 8'h00;
      rsrc_s    = 4'h0;
      rdest_s   = 4'h0;
      imm_s     = 16'h0000;
      illegal_s = illegal_r;
      case (state_r)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_s   = S_FETCH;
               pc_s      = {ADDR_W{1'b0}};
               illegal_s = 1'b0;
            end else begin
               state_s   = state_r;
            end
         end
         S_FETCH: state_s = S_WAIT;
         S_WAIT: begin
            state_s   = S_EXEC;
            ir_s      = instr_data;
            reg_en_s  = dec_s.reg_en;
            flag_en_s = dec_s.flag_en;
            rori_s    = dec_s.rori;
            imm_s     = dec_s.imm;
            opcode_s  = {instr_data[15:12], instr_data[7:4]};
            rsrc_s    = instr_data[3:0];
            rdest_s   = instr_data[11:8];
            if (dec_s.legal) begin
               illegal_s = illegal_r;
            end else begin
               illegal_s = 1'b1;
            end
         end
         S_EXEC: begin
            // the HALT word holds PC so that it still points at the HALT word
            if (ir_r == 16'h0000) begin
               state_s = S_HALT;
            end else begin
               state_s = S_FETCH;
               pc_s    = pc_r + PC_STEP;
            end
         end
         default: state_s = S_IDLE;
      endcase
      busy_s   = (state_s == S_FETCH) || (state_s == S_WAIT) || (state_s == S_EXEC);
      halted_s = (state_s == S_HALT);
   end

   // State, PC, IR and registered control outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         pc_r      <= {ADDR_W{1'b0}};
         ir_r      <= 16'h0000;
         reg_en_r  <= 16'h0000;
         flag_en_r <= 1'b0;
         rori_r    <= 1'b0;
         opcode_r  <= 8'h00;
         rsrc_r    <= 4'h0;
         rdest_r   <= 4'h0;
         imm_r     <= 16'h0000;
         busy_r    <= 1'b0;
         halted_r  <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         ir_r      <= ir_s;
         reg_en_r  <= reg_en_s;
         flag_en_r <= flag_en_s;
         rori_r    <= rori_s;
         opcode_r  <= opcode_s;
         rsrc_r    <= rsrc_s;
         rdest_r   <= rdest_s;
         imm_r     <= imm_s;
         busy_r    <= busy_s;
         halted_r  <= halted_s;
         illegal_r <= illegal_s;
      end
   end

   assign instr_addr = pc_r;
   assign regEnable  = reg_en_r;
   assign flagEn     = flag_en_r;
   assign RorI       = rori_r;
   assign opcode     = opcode_r;
   assign Rsrc       = rsrc_r;
   assign Rdest      = rdest_r;
   assign imm        = imm_r;
   assign busy       = busy_r;
   assign halted     = halted_r;
   assign illegal    = illegal_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. Expected EXEC-cycle bundles are
// queued when a program is loaded and popped when the EXEC cycle is sampled.
// A second instance with ADDR_W=2 exercises PC wrap-around.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data;
   logic [15:0] regEnable, imm;
   logic        flagEn, RorI, busy, halted, illegal;
   logic [7:0]  opcode;
   logic [3:0]  Rsrc, Rdest;

   logic        rst2, start2;
   logic [1:0]  instr_addr2;
   logic [15:0] instr_data2;
   logic [15:0] regEnable2, imm2;
   logic        flagEn2, RorI2, busy2, halted2, illegal2;
   logic [7:0]  opcode2;
   logic [3:0]  Rsrc2, Rdest2;

   logic [15:0] rom  [256];
   logic [15:0] rom2 [4];

   alu_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .instr_addr(instr_addr), .instr_data(instr_data),
      .regEnable(regEnable), .flagEn(flagEn), .RorI(RorI), .opcode(opcode),
      .Rsrc(Rsrc), .Rdest(Rdest), .imm(imm),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   alu_sequencer #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst2), .start(start2),
      .instr_addr(instr_addr2), .instr_data(instr_data2),
      .regEnable(regEnable2), .flagEn(flagEn2), .RorI(RorI2), .opcode(opcode2),
      .Rsrc(Rsrc2), .Rdest(Rdest2), .imm(imm2),
      .busy(busy2), .halted(halted2), .illegal(illegal2)
   );

   // synchronous ROM models: data one cycle after the address
   always_ff @(posedge clk) instr_data  <= rom[instr_addr];
   always_ff @(posedge clk) instr_data2 <= rom2[instr_addr2];

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] reg_en;
      logic        flag;
      logic        rori;
      logic [7:0]  op;
      logic [3:0]  rsrc;
      logic [3:0]  rdest;
      logic [15:0] imm;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc, input logic [15:0] re, input logic f,
                           input logic r, input logic [7:0] op, input logic [3:0] rs,
                           input logic [3:0] rd, input logic [15:0] im, input logic il);
      exp_t e;
      e = {pc, re, f, r, op, rs, rd, im, il};
      sb_q.push_back(e);
   endtask

   task automatic check_exec(input string tag, input logic second);
      exp_t e, o;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         if (second) begin
            o = {6'b000000, instr_addr2, regEnable2, flagEn2, RorI2, opcode2, Rsrc2, Rdest2, imm2, illegal2};
         end else begin
            o = {instr_addr, regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm, illegal};
         end
         check_val(tag, 64'(o), 64'(e));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a negedge; returns at the negedge after the start edge (FETCH)
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      for (int i = 0; i < 4; i++) rom2[i] = 16'h0551;   // ADD R5,R1
      tick(2);
      rst = 1'b0; rst2 = 1'b0;
      check_val("reset_outputs",
                64'({instr_addr, regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm, busy, halted, illegal}),
                64'h0);

      // illegal word, then HALT
      rom[0] = 16'hF000; rom[1] = 16'h0000;
      push_exp(8'h00, 16'h0000, 1'b0, 1'b0, 8'hF0, 4'h0, 4'h0, 16'h0000, 1'b1);
      push_exp(8'h01, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1);
      pulse_start();
      check_val("busy_after_start", 64'(busy), 64'h1);
      tick(2); check_exec("illegal_exec", 1'b0);
      tick(3); check_exec("halt_after_illegal", 1'b0);
      tick(1);
      check_val("halt_state_illegal", 64'({instr_addr, busy, halted, illegal, regEnable}),
                64'({8'h01, 1'b0, 1'b1, 1'b1, 16'h0000}));

      // MOVI R2,#0x14 ; MOV R1,R2 ; HALT -- start also clears illegal
      rom[0] = 16'hD214; rom[1] = 16'h01D2; rom[2] = 16'h0000;
      push_exp(8'h00, 16'h0004, 1'b0, 1'b1, 8'hD1, 4'h4, 4'h2, 16'h0014, 1'b0);
      push_exp(8'h01, 16'h0002, 1'b0, 1'b0, 8'h0D, 4'h2, 4'h1, 16'h0000, 1'b0);
      push_exp(8'h02, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b0);
      pulse_start();
      check_val("start_clears_illegal", 64'(illegal), 64'h0);
      tick(2); check_exec("movi", 1'b0);
      tick(3); check_exec("mov", 1'b0);
      tick(3); check_exec("halt_word", 1'b0);
      tick(1);
      check_val("halted_pc2", 64'({instr_addr, busy, halted}), 64'({8'h02, 1'b0, 1'b1}));
      tick(4);
      check_val("halted_hold", 64'({instr_addr, busy, halted, regEnable}), 64'({8'h02, 1'b0, 1'b1, 16'h0000}));

      // SUBI R3,#-1 ; CMPI R11,#0x25 ; ADDUI R10,#0xFF ; HALT
      rom[0] = 16'h93FF; rom[1] = 16'hBB25; rom[2] = 16'h6AFF; rom[3] = 16'h0000;
      push_exp(8'h00, 16'h0008, 1'b1, 1'b1, 8'h9F, 4'hF, 4'h3, 16'hFFFF, 1'b0);
      push_exp(8'h01, 16'h0000, 1'b1, 1'b1, 8'hB2, 4'h5, 4'hB, 16'h0025, 1'b0);
      push_exp(8'h02, 16'h0400, 1'b1, 1'b1, 8'h6F, 4'hF, 4'hA, 16'h00FF, 1'b0);
      push_exp(8'h03, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b0);
      pulse_start();
      tick(2); check_exec("subi", 1'b0);
      tick(3); check_exec("cmpi", 1'b0);
      tick(3); check_exec("addui", 1'b0);
      tick(3); check_exec("halt_word2", 1'b0);

      // shifts: LSHI +3, LSHI -13, LSH R4,R1, ASHUI -13, HALT
      rom[0] = 16'h8403; rom[1] = 16'h8413; rom[2] = 16'h8481;
      rom[3] = 16'h8433; rom[4] = 16'h0000;
      push_exp(8'h00, 16'h0010, 1'b0, 1'b1, 8'h80, 4'h3, 4'h4, 16'h0003, 1'b0);
      push_exp(8'h01, 16'h0010, 1'b0, 1'b1, 8'h81, 4'h3, 4'h4, 16'hFFF3, 1'b0);
      push_exp(8'h02, 16'h0010, 1'b0, 1'b0, 8'h88, 4'h1, 4'h4, 16'h0000, 1'b0);
      push_exp(8'h03, 16'h0010, 1'b0, 1'b1, 8'h83, 4'h3, 4'h4, 16'hFFF3, 1'b0);
      push_exp(8'h04, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b0);
      tick(1);
      pulse_start();
      tick(2); check_exec("lshi_pos", 1'b0);
      tick(3); check_exec("lshi_neg", 1'b0);
      tick(3); check_exec("lsh_reg", 1'b0);
      tick(3); check_exec("ashui_neg", 1'b0);
      tick(3); check_exec("halt_word3", 1'b0);

      // reset held two cycles during EXEC; start alongside rst is ignored
      rom[0] = 16'hD214; rom[1] = 16'h01D2; rom[2] = 16'h0000;
      pulse_start();
      tick(2);
      rst = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      rst = 1'b0;
      check_val("reset_mid_exec",
                64'({instr_addr, regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm, busy, halted, illegal}),
                64'h0);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check_val("no_write_after_rst", 64'({regEnable, busy, instr_addr}), 64'h0);
      end

      // ADDR_W=2: PC 0,1,2,3,0; a start pulse mid-run is ignored
      push_exp(8'h00, 16'h0020, 1'b1, 1'b0, 8'h05, 4'h1, 4'h5, 16'h0000, 1'b0);
      push_exp(8'h01, 16'h0020, 1'b1, 1'b0, 8'h05, 4'h1, 4'h5, 16'h0000, 1'b0);
      push_exp(8'h02, 16'h0020, 1'b1, 1'b0, 8'h05, 4'h1, 4'h5, 16'h0000, 1'b0);
      push_exp(8'h03, 16'h0020, 1'b1, 1'b0, 8'h05, 4'h1, 4'h5, 16'h0000, 1'b0);
      push_exp(8'h00, 16'h0020, 1'b1, 1'b0, 8'h05, 4'h1, 4'h5, 16'h0000, 1'b0);
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      tick(2); check_exec("wrap_pc0", 1'b1);
      tick(3); check_exec("wrap_pc1", 1'b1);
      tick(1);
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      tick(1); check_exec("wrap_pc2_start_ignored", 1'b1);
      tick(3); check_exec("wrap_pc3", 1'b1);
      tick(3); check_exec("wrap_pc0_again", 1'b1);
      rst2 = 1'b1;
      tick(1);
      rst2 = 1'b0;

      check_val("scoreboard_drained", 64'(sb_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
